// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch state encoding and default widths
package fetch_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam int D_DEF  = 10;
   localparam int CW_DEF = 16;
endpackage

// File: rtl/pc_next.sv
// pc_next: next program counter for sequential, absolute and relative flow
module pc_next #(
   parameter int D = fetch_pkg::D_DEF
) (
   input  logic [D-1:0] pc,
   input  logic         branch_en,
   input  logic         branch_abs,
   input  logic [D-1:0] target,
   output logic [D-1:0] nxt
);
   // relative offsets are two's complement, so a plain modulo-2^D add covers negative jumps
   always_comb nxt = !branch_en ? pc + D'(1) : branch_abs ? target : pc + target;
endmodule

// File: rtl/pc_fetch.sv
// pc_fetch: program counter sequencer with IDLE/RUN/DONE control and retire count
module pc_fetch
   import fetch_pkg::*;
#(
   parameter int D  = D_DEF,
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          start,
   input  logic          stall,
   input  logic          branch_en,
   input  logic          branch_abs,
   input  logic [D-1:0]  target,
   input  logic          halt,
   output logic [D-1:0]  pc,
   output logic          fetch_valid,
   output logic          done,
   output logic [CW-1:0] retired
);
   state_t        state, state_d;
   logic [D-1:0]  pc_d, pc_nx;
   logic [CW-1:0] retired_d;
   logic          go, adv;

   pc_next #(.D(D)) u_pc_next (
      .pc(pc),
      .branch_en(branch_en),
      .branch_abs(branch_abs),
      .target(target),
      .nxt(pc_nx)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         pc      <= '0;
         retired <= '0;
      end else begin
         state   <= state_d;
         pc      <= pc_d;
         retired <= retired_d;
      end
   end

   // start only matters outside RUN; halt retires its instruction but freezes pc
   always_comb begin
      go        = start && state != RUN;
      adv       = state == RUN && !stall;
      state_d   = go ? RUN : adv && halt ? DONE : state;
      pc_d      = go ? '0 : adv && !halt ? pc_nx : pc;
      retired_d = go ? '0 : adv ? retired + CW'(1) : retired;
   end

   assign fetch_valid = state == RUN;
   assign done        = state == DONE;
endmodule

// File: tb/tb_pc_fetch.sv
// tb_pc_fetch: directed checks of pc_fetch sequencing, branching, stall, halt and reset
module tb_pc_fetch;
   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0, stall = 1'b0, branch_en = 1'b0, branch_abs = 1'b0, halt = 1'b0;
   logic [9:0]  target = '0;
   logic [9:0]  pc;
   logic        fetch_valid, done;
   logic [15:0] retired;
   int          vectors = 0;
   int          errs = 0;

   pc_fetch dut (
      .clk(clk), .reset_n(reset_n), .start(start), .stall(stall),
      .branch_en(branch_en), .branch_abs(branch_abs), .target(target), .halt(halt),
      .pc(pc), .fetch_valid(fetch_valid), .done(done), .retired(retired)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input int epc, input int eret, input logic efv, input logic edone);
      chk({tag, ".pc"}, 32'(pc), 32'(epc));
      chk({tag, ".retired"}, 32'(retired), 32'(eret));
      chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(efv));
      chk({tag, ".done"}, 32'(done), 32'(edone));
   endtask

   task automatic br(input logic en, input logic abs_t, input int t);
      branch_en = en;
      branch_abs = abs_t;
      target = 10'(t);
   endtask

   initial begin
      #12;
      chk_all("reset", 0, 0, 0, 0);
      reset_n = 1'b1;
      br(1, 1, 300);
      halt = 1'b1;
      step();
      step();
      chk_all("idle_hold", 0, 0, 0, 0);
      halt = 1'b0;
      br(0, 0, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("start", 0, 0, 1, 0);
      step();
      chk_all("seq1", 1, 1, 1, 0);
      step();
      chk_all("seq2", 2, 2, 1, 0);
      step();
      chk_all("seq3", 3, 3, 1, 0);
      br(1, 1, 44);
      step();
      chk_all("abs44", 44, 4, 1, 0);
      br(1, 0, 1023);
      step();
      chk_all("rel_m1", 43, 5, 1, 0);
      br(1, 1, 1023);
      step();
      chk("abs1023.pc", 32'(pc), 1023);
      br(0, 0, 0);
      step();
      chk_all("wrap", 0, 7, 1, 0);
      br(1, 1, 1020);
      step();
      chk("abs1020.pc", 32'(pc), 1020);
      br(1, 0, 20);
      step();
      chk_all("rel_wrap", 16, 9, 1, 0);
      br(1, 1, 11);
      step();
      chk("abs11.pc", 32'(pc), 11);
      stall = 1'b1;
      halt = 1'b1;
      br(1, 1, 500);
      step();
      chk_all("stall1", 11, 10, 1, 0);
      step();
      chk_all("stall2", 11, 10, 1, 0);
      stall = 1'b0;
      halt = 1'b0;
      br(0, 0, 0);
      step();
      chk_all("unstall", 12, 11, 1, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("start_in_run", 13, 12, 1, 0);
      br(1, 1, 116);
      step();
      chk("abs116.pc", 32'(pc), 116);
      br(1, 1, 7);
      halt = 1'b1;
      step();
      chk_all("halt", 116, 14, 0, 1);
      halt = 1'b0;
      step();
      chk_all("done_hold", 116, 14, 0, 1);
      br(0, 0, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      chk_all("restart", 0, 0, 1, 0);
      br(1, 1, 57);
      step();
      chk_all("abs57", 57, 1, 1, 0);
      #2;
      reset_n = 1'b0;
      #1;
      chk_all("async_reset", 0, 0, 0, 0);
      step();
      br(0, 0, 0);
      #2;
      reset_n = 1'b1;
      step();
      step();
      chk_all("post_reset_idle", 0, 0, 0, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      chk_all("run_after_reset", 1, 1, 1, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/pc_fetch.md
PC_FETCH -- requirements
Module: pc_fetch

Interface
REQ-001 SHALL have parameter D, default 10, the program counter and branch target width in bits.
REQ-002 SHALL have parameter CW, default 16, the retired-instruction counter width in bits.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  one-cycle request to begin execution from address 0.
REQ-006 SHALL have port stall  input  1  holds pc and counters for the cycle while high.
REQ-007 SHALL have port branch_en  input  1  taken branch/jump in the current instruction.
REQ-008 SHALL have port branch_abs  input  1  1 = absolute target, 0 = PC-relative offset.
REQ-009 SHALL have port target  input  D  branch target or offset from the upstream target lookup table.
REQ-010 SHALL have port halt  input  1  current instruction is the program-done instruction.
REQ-011 SHALL have port pc  output  D  address of the instruction currently being fetched.
REQ-012 SHALL have port fetch_valid  output  1  pc is a live fetch address (RUN state only).
REQ-013 SHALL have port done  output  1  program finished; level signal, high in DONE state.
REQ-014 SHALL have port retired  output  CW  count of instructions retired since the last start.

Function
REQ-015 SHALL implement three states: IDLE, RUN and DONE.
REQ-016 SHALL go from IDLE to RUN on start=1, loading pc=0 and retired=0 at the same edge.
REQ-017 SHALL, in RUN with stall=0 and halt=0, retire one instruction per cycle: retired increments by 1 and pc gets its next value.
REQ-018 SHALL compute next pc as pc+1 when branch_en=0, as target when branch_en=1 and branch_abs=1, and as pc+target when branch_en=1 and branch_abs=0.
REQ-019 SHALL perform all pc arithmetic modulo 2^D; a relative offset is two's complement, so target=2^D-1 means -1.
REQ-020 SHALL wrap pc from 2^D-1 to 0 on sequential increment and SHALL NOT flag any error.
REQ-021 SHALL wrap retired to 0 past 2^CW-1 (saturation not required).
REQ-022 SHALL, in RUN with stall=1, hold pc and retired and ignore branch_en, branch_abs and halt for that cycle.
REQ-023 SHALL, in RUN with stall=0 and halt=1, go to DONE, increment retired, and hold pc; halt has priority over branch_en.
REQ-024 SHALL ignore start while in RUN.
REQ-025 SHALL hold pc and retired in DONE, with done=1 and fetch_valid=0.
REQ-026 SHALL restart from DONE on start=1 exactly as from IDLE: pc=0, retired=0, state RUN.
REQ-027 SHALL drive fetch_valid=1 only in RUN and done=1 only in DONE; both SHALL be registered-state decodes with no combinational path from inputs.
REQ-028 SHALL hold pc at its value in IDLE and ignore branch and halt inputs outside RUN.

Reset
REQ-029 SHALL, on reset_n=0 at any time including mid-RUN, immediately force state=IDLE, pc=0, retired=0, fetch_valid=0 and done=0.
REQ-030 SHALL remain in IDLE after reset_n deasserts until start=1 is sampled on a clock edge.

Structure
REQ-031 SHALL take the state enum (IDLE/RUN/DONE) and the default D and CW values from a shared package, fetch_pkg.
REQ-032 SHALL put next-pc arithmetic in one combinational sub-module, pc_next (inputs pc, branch_en, branch_abs, target; output next pc), for reuse by the branch-predict work.
REQ-033 SHALL be connected so that target is wired directly from the target lookup table output, with no retiming in this block.

Verification
REQ-034 SHALL be verified with: reset_n=0 mid-RUN at pc=57 -> pc=0, state IDLE, done=0 and fetch_valid=0 before the next clock edge.
REQ-035 SHALL be verified with: start, then 3 cycles with no branch -> pc=0,1,2,3, retired=3, fetch_valid=1.
REQ-036 SHALL be verified with: at pc=3, branch_en=1, branch_abs=1, target=44 -> pc=44; then branch_abs=0, target=1023 -> pc=43.
REQ-037 SHALL be verified with: pc=1023, branch_en=0 -> pc=0; pc=1020, relative target=20 -> pc=16.
REQ-038 SHALL be verified with: stall=1 for 2 cycles at pc=11 with branch_en=1 -> pc stays 11 and retired is unchanged.
REQ-039 SHALL be verified with: halt=1 together with branch_en=1 at pc=116 -> DONE, pc=116, done=1; start ignored in RUN and restarts at pc=0 from DONE.
